uart_rx_decoder: RTL and testbench
==================================

Name: uart_rx_decoder

Overview:
- Synthesizable UART receiver that decodes the serial stream on the SoC GPIO/UART output line into bytes.
- Format is 8N1: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- The bit period is a run-time divisor input; a divisor of 0 disables decoding, i.e. the line is plain GPIO.
- Sits beside the subservient SoC and delivers one-cycle byte strobes to a console/logger or host interface.

Parameters:
DIV_W, 16, width of the baud divisor input (clock cycles per bit).

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_rst_n  input  1  reset, asynchronous assert, active-low.
i_baud_div  input  DIV_W  clock cycles per bit; 0 = decoder disabled; legal values 0 or >=4.
i_rx  input  1  serial line; idles high; asynchronous to i_clk.
o_data  output  8  last received byte.
o_valid  output  1  one-cycle strobe: o_data holds a good byte.
o_frame_err  output  1  one-cycle strobe: stop bit sampled low.
o_busy  output  1  high while a frame is in progress (states START..STOP, and BREAK).

Behaviour:
- Reset: o_data=0x00, o_valid=0, o_frame_err=0, o_busy=0, state IDLE, both synchronizer flops=1.
- Synchronizer: i_rx passes through 2 flops; the result is rx_s. All sampling uses rx_s, so there are 2 cycles of input latency.
- Disabled (i_baud_div==0): FSM is held in IDLE; no strobes.
- Divisor latch: div is captured on start detection. Changes to i_baud_div mid-frame take effect from the next frame only.
- IDLE: when rx_s==0 and div!=0, latch div and load counter to div>>1. Go to START.
- START: decrement counter each cycle; at 0, sample rx_s.
  - Sample 0: reload counter to div; go to DATA with bit index 0.
  - Sample 1: false start; return to IDLE with no strobe.
- DATA: at each counter expiry, shift rx_s into the shift register, LSB first (bit n lands in position n), then reload div. After the 8th sample, go to STOP.
- STOP: at counter expiry, sample rx_s.
  - Sample 1: next cycle o_data=shift register and o_valid=1 for exactly 1 cycle. Return to IDLE.
  - Sample 0: next cycle o_data=shift register and o_frame_err=1 for 1 cycle. Go to BREAK.
- BREAK: wait until rx_s==1, then IDLE. A held-low line produces only one error and no further frames.
- Sampling instants: with edge-detect cycle E, samples fall at E+(div>>1), then every div cycles. The stop sample is at E+(div>>1)+9*div. The strobe is 1 cycle later.
- Back-to-back frames: IDLE re-arms on the cycle after the strobe. A start edge arriving within the second half of the stop bit is accepted.
- o_valid and o_frame_err are never high together. Outside strobes, o_data holds its last value.
- Counter width is DIV_W; no wrap issues, since reload is always <= div.
- Asynchronous reset mid-frame: all outputs clear immediately. The partial byte is discarded. Decoding restarts from IDLE after release.

Test Plan:
- div=10: send 0x55 at 10 cycles/bit after idle high -> exactly one o_valid, o_data=0x55, strobe 2+5+90+1 cycles after the start falling edge; o_frame_err stays 0.
- div=16: send 0x48 then 0x69 back-to-back, 1 stop bit each -> two o_valid pulses with o_data 0x48 then 0x69; o_busy low only between frames.
- div=10: low glitch of 3 cycles on i_rx -> no strobe; o_busy returns to 0 after the START sample.
- div=10: send 0xA3 with stop bit driven 0, then hold line low 50 cycles -> single o_frame_err pulse, o_data=0xA3, no o_valid. Next valid frame (0x31) decodes correctly after the line returns high.
- i_baud_div=0: toggle i_rx arbitrarily for 500 cycles -> o_valid, o_frame_err and o_busy remain 0.
- div=8: assert i_rst_n=0 asynchronously during bit 4 of a frame -> outputs 0 at once. After release, a following byte 0x7E decodes with o_valid and o_data=0x7E.

Source files
------------

// File: rtl/uart_rx_decoder.sv
// uart_rx_decoder: 8N1 UART receiver with run-time baud divisor and one-cycle byte/error strobes
module uart_rx_decoder #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_baud_div,
    input  logic             i_rx,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_frame_err,
    output logic             o_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t           state;
    logic [1:0]       sync;
    logic             rx_s;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             tick;
    assign rx_s = sync[1];
    // cnt holds the cycles remaining until the next sample, so the sample fires when it reaches 1
    assign tick = (cnt == DIV_W'(1));
    // two-flop synchronizer for the asynchronous serial line, idling high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            sync <= 2'b11;
        else
            sync <= {sync[0], i_rx};
    end
    // frame FSM: start detection, mid-bit sampling, byte assembly and registered strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            div         <= '0;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            cnt         <= cnt - DIV_W'(1);
            case (state)
                IDLE: if (!rx_s && i_baud_div != '0) begin
                    div    <= i_baud_div;
                    cnt    <= i_baud_div >> 1;
                    state  <= START;
                    o_busy <= 1'b1;
                end
                START: if (tick) begin
                    if (rx_s) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        cnt   <= div;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: if (tick) begin
                    shift <= {rx_s, shift[7:1]};
                    cnt   <= div;
                    idx   <= idx + 3'd1;
                    if (idx == 3'd7)
                        state <= STOP;
                end
                STOP: if (tick) begin
                    o_data      <= shift;
                    o_valid     <= rx_s;
                    o_frame_err <= !rx_s;
                    o_busy      <= !rx_s;
                    state       <= rx_s ? IDLE : BRK;
                end
                BRK: if (rx_s) begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_decoder.sv
// tb_uart_rx_decoder: directed UART frames checked every cycle against a frame-timing scoreboard
module tb_uart_rx_decoder;
    localparam int DIV_W = 16;
    localparam int NC    = 8192;
    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_rx = 1'b1;
    logic [DIV_W-1:0] i_baud_div = '0;
    logic [7:0]       o_data;
    logic             o_valid;
    logic             o_frame_err;
    logic             o_busy;
    int               cyc = 0;
    int               total = 0;
    int               passed = 0;
    bit               exp_v [NC];
    bit               exp_e [NC];
    bit               exp_b [NC];
    logic [7:0]       exp_d [NC];
    logic [7:0]       mdl_data = 8'h00;
    logic [7:0]       got_q [$];
    int               n_err = 0;
    int               last_v_cyc = -1;
    int               n0;
    uart_rx_decoder #(.DIV_W(DIV_W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_baud_div (i_baud_div),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endfunction
    // cycle-by-cycle comparison against the scoreboard, away from the active edge
    always @(negedge i_clk) begin
        if (!i_rst_n)
            mdl_data = 8'h00;
        if (cyc < NC) begin
            if (exp_v[cyc] || exp_e[cyc])
                mdl_data = exp_d[cyc];
            check("o_valid", 32'(o_valid), 32'(exp_v[cyc]));
            check("o_frame_err", 32'(o_frame_err), 32'(exp_e[cyc]));
            check("o_busy", 32'(o_busy), 32'(exp_b[cyc]));
            check("o_data", 32'(o_data), 32'(mdl_data));
        end
        if (o_valid) begin
            got_q.push_back(o_data);
            last_v_cyc = cyc;
        end
        if (o_frame_err)
            n_err++;
    end
    // advance k cycles, leaving the caller 1 time unit after a rising edge
    task automatic hold(input int k);
        repeat (k) @(posedge i_clk);
        if (k > 0) #1;
    endtask
    // send one frame at dv cycles/bit; the line falls at the current cycle n, the receiver
    // detects it 3 edges later, samples mid-bit and strobes right after the stop sample
    task automatic frame(input logic [7:0] d, input logic ok, input int low, input int dv, input int mdv);
        int n, e, s, last;
        n    = cyc;
        e    = n + 3;
        s    = e + (dv >> 1) + 9 * dv;
        last = ok ? s - 1 : n + 10 * dv + low + 2;
        for (int c = e; c <= last && c < NC; c++) exp_b[c] = 1'b1;
        exp_v[s] = ok;
        exp_e[s] = !ok;
        exp_d[s] = d;
        i_baud_div = DIV_W'(dv);
        i_rx = 1'b0;
        hold(dv);
        i_baud_div = DIV_W'(mdv);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            hold(dv);
        end
        i_rx = ok;
        hold(dv);
        if (!ok) begin
            hold(low);
            i_rx = 1'b1;
        end
    endtask
    // short low pulse: receiver enters START and abandons it at the mid-bit sample
    task automatic glitch(input int len);
        int n, e, h;
        n = cyc;
        e = n + 3;
        h = int'(i_baud_div >> 1);
        for (int c = e; c < e + h; c++) exp_b[c] = 1'b1;
        i_rx = 1'b0;
        hold(len);
        i_rx = 1'b1;
    endtask
    initial begin
        logic [7:0] part;
        hold(3);
        check("reset o_data", 32'(o_data), 32'h0);
        check("reset o_valid", 32'(o_valid), 32'h0);
        check("reset o_frame_err", 32'(o_frame_err), 32'h0);
        check("reset o_busy", 32'(o_busy), 32'h0);
        i_rst_n = 1'b1;
        hold(5);
        n0 = cyc;
        frame(8'h55, 1'b1, 0, 10, 10);
        hold(20);
        check("t1 count", 32'(got_q.size()), 32'd1);
        check("t1 data", 32'(got_q[0]), 32'h55);
        check("t1 latency", 32'(last_v_cyc - n0), 32'd98);
        check("t1 no error", 32'(n_err), 32'd0);
        got_q.delete();
        frame(8'h48, 1'b1, 0, 16, 16);
        frame(8'h69, 1'b1, 0, 16, 16);
        hold(20);
        check("t2 count", 32'(got_q.size()), 32'd2);
        check("t2 first", 32'(got_q[0]), 32'h48);
        check("t2 second", 32'(got_q[1]), 32'h69);
        got_q.delete();
        i_baud_div = 16'd10;
        hold(5);
        glitch(3);
        hold(20);
        check("t3 no strobe", 32'(got_q.size() + n_err), 32'd0);
        frame(8'hA3, 1'b0, 50, 10, 10);
        hold(20);
        check("t4 error count", 32'(n_err), 32'd1);
        check("t4 no valid", 32'(got_q.size()), 32'd0);
        check("t4 data held", 32'(o_data), 32'hA3);
        frame(8'h31, 1'b1, 0, 10, 10);
        hold(20);
        check("t4 recovery count", 32'(got_q.size()), 32'd1);
        check("t4 recovery data", 32'(got_q[0]), 32'h31);
        check("t4 single error", 32'(n_err), 32'd1);
        got_q.delete();
        i_baud_div = '0;
        repeat (500) begin
            i_rx = 1'($urandom);
            hold(1);
        end
        i_rx = 1'b1;
        hold(5);
        check("t5 no valid", 32'(got_q.size()), 32'd0);
        check("t5 no error", 32'(n_err), 32'd1);
        frame(8'h96, 1'b1, 0, 10, 37);
        hold(20);
        check("latch count", 32'(got_q.size()), 32'd1);
        check("latch data", 32'(got_q[0]), 32'h96);
        got_q.delete();
        part = 8'hC5;
        i_baud_div = 16'd8;
        n0 = cyc;
        for (int c = n0 + 3; c <= n0 + 42; c++) exp_b[c] = 1'b1;
        i_rx = 1'b0;
        hold(8);
        for (int i = 0; i < 4; i++) begin
            i_rx = part[i];
            hold(8);
        end
        i_rx = part[4];
        hold(3);
        #2 i_rst_n = 1'b0;
        #1;
        check("t6 async o_data", 32'(o_data), 32'h0);
        check("t6 async o_valid", 32'(o_valid), 32'h0);
        check("t6 async o_frame_err", 32'(o_frame_err), 32'h0);
        check("t6 async o_busy", 32'(o_busy), 32'h0);
        i_rx = 1'b1;
        hold(4);
        i_rst_n = 1'b1;
        hold(10);
        frame(8'h7E, 1'b1, 0, 8, 8);
        hold(20);
        check("t6 count", 32'(got_q.size()), 32'd1);
        check("t6 data", 32'(got_q[0]), 32'h7E);
        check("t6 no error", 32'(n_err), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
